// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, default widths and load-unit FSM states shared across the pipeline.
package cpu_pkg;
  localparam logic [7:0] OPCODE_READRAM8 = 8'd1;
  localparam logic [7:0] OPCODE_JUMPMINUS = 8'd2;
  localparam int ADDR_W_DEF = 16;
  localparam int REG_W_DEF = 9;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} load_state_t;
endpackage

// File: rtl/load_req_fifo.sv
// load_req_fifo: circular request queue holding {addr, reg} pairs for the load unit.
module load_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 25
) (
  input  logic         ram_clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push_ok, pop_ok;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign push_ok = push & !full;
  assign pop_ok = pop & !empty;
  assign dout = mem[rp];
  always_ff @(posedge ram_clk)
    if (push_ok) mem[wp] <= din;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge ram_clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(push_ok);
      rp <= rp + AW'(pop_ok);
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/stage3_load_unit.sv
// stage3_load_unit: queues READRAM8 ops, reads one byte per op from the arbiter, writes it to the register file.
module stage3_load_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TIMEOUT = 16,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_W = REG_W_DEF
) (
  input  logic              ram_clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [7:0]        dec_opcode,
  input  logic [ADDR_W-1:0] dec_addr,
  input  logic [REG_W-1:0]  dec_reg,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_ack,
  input  logic [7:0]        ram_data,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [7:0]        rf_wdata,
  output logic              busy,
  output logic              err
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  load_state_t state, state_n;
  logic [ADDR_W+REG_W-1:0] head;
  logic [CW-1:0] cnt;
  logic push, pop, full, empty, tmo;
  assign dec_ready = !full;
  assign push = dec_valid & !full & (dec_opcode == OPCODE_READRAM8);
  assign pop = (state == IDLE) & !empty;
  assign tmo = cnt == CNT_MAX;
  assign rf_we = state == WB;
  assign busy = !empty | (state != IDLE);
  load_req_fifo #(.DEPTH(DEPTH), .W(ADDR_W + REG_W)) u_fifo (
    .ram_clk(ram_clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din({dec_addr, dec_reg}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge ram_clk)
    state <= !rst ? IDLE : state_n;
  // An ack coinciding with the last timeout cycle still completes the load.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = empty ? IDLE : REQ;
      REQ: state_n = WAIT;
      WAIT: state_n = ram_ack ? WB : (tmo ? IDLE : WAIT);
      WB: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge ram_clk) begin
    if (!rst) begin
      ram_req <= 1'b0;
      ram_addr <= '0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (pop) {ram_addr, rf_waddr} <= head;
      ram_req <= state_n == WAIT;
      cnt <= (state == WAIT) ? cnt + CW'(1) : '0;
      if (state == WAIT && ram_ack) rf_wdata <= ram_data;
      if (state == WAIT && !ram_ack && tmo) err <= 1'b1;
    end
  end
endmodule
